// File: rtl/contador_param.sv
// Parametrised up/down counter with synchronous parallel load, cascade enable,
// wrap-or-saturate policy, a registered carry/borrow pulse and a sticky overflow flag.
module contador_param #(
  parameter int WIDTH    = 32,
  parameter int STEP     = 3,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             CASC_IN,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] CARGA,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             OVF
);

  typedef enum logic [1:0] {
    MODO_UP        = 2'd0,
    MODO_DOWN      = 2'd1,
    MODO_DOWN_STEP = 2'd2,
    MODO_LOAD      = 2'd3
  } modo_e;

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
  localparam bit             SAT    = (SATURATE != 0);

  modo_e            modo;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_diff;
  logic [WIDTH:0]   dn_amount;

  assign modo = modo_e'(MODO);

  // The extra top bit of each WIDTH+1 result is the carry (up) or borrow (down) event.
  assign dn_amount = (modo == MODO_DOWN_STEP) ? STEP_W : ONE_W;
  assign up_sum    = {1'b0, q_q} + ONE_W;
  assign dn_diff   = {1'b0, q_q} - dn_amount;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    q_d   = q_q;
    rco_d = 1'b0;
    ovf_d = ovf_q;
    if (ENABLE) begin
      if (modo == MODO_LOAD) begin
        q_d   = CARGA;
        ovf_d = 1'b0;
      end else if (CASC_IN) begin
        unique case (modo)
          MODO_UP: begin
            rco_d = up_sum[WIDTH];
            q_d   = (up_sum[WIDTH] && SAT) ? '1 : up_sum[WIDTH-1:0];
          end
          MODO_DOWN, MODO_DOWN_STEP: begin
            rco_d = dn_diff[WIDTH];
            q_d   = (dn_diff[WIDTH] && SAT) ? '0 : dn_diff[WIDTH-1:0];
          end
          default: ;
        endcase
        if (rco_d) ovf_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      q_q   <= '0;
      rco_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rco_q <= rco_d;
      ovf_q <= ovf_d;
    end
  end

  assign Q   = q_q;
  assign RCO = rco_q;
  assign OVF = ovf_q;

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench: four counter variants (wide/narrow, wrap/saturate) driven by shared
// directed and random stimulus, compared against an arithmetic reference model.
module tb_contador_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        casc;
  logic [1:0]  modo;
  logic [31:0] carga;

  logic [31:0] q0, q1;
  logic [3:0]  q2, q3;
  logic [3:0]  rco_v, ovf_v;

  int checks   = 0;
  int failures = 0;

  // Variant table: width, step, saturate.
  int vw  [4] = '{32, 32, 4, 4};
  int vs  [4] = '{3, 3, 5, 5};
  int vsat[4] = '{0, 1, 0, 1};

  logic [63:0] m_q  [4];
  logic        m_rco[4];
  logic        m_ovf[4];

  always #5 clk = ~clk;

  contador_param #(.WIDTH(32), .STEP(3), .SATURATE(0)) u_w32_wrap (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CASC_IN(casc), .MODO(modo),
    .CARGA(carga), .Q(q0), .RCO(rco_v[0]), .OVF(ovf_v[0]));
  contador_param #(.WIDTH(32), .STEP(3), .SATURATE(1)) u_w32_sat (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CASC_IN(casc), .MODO(modo),
    .CARGA(carga), .Q(q1), .RCO(rco_v[1]), .OVF(ovf_v[1]));
  contador_param #(.WIDTH(4), .STEP(5), .SATURATE(0)) u_w4_wrap (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CASC_IN(casc), .MODO(modo),
    .CARGA(carga[3:0]), .Q(q2), .RCO(rco_v[2]), .OVF(ovf_v[2]));
  contador_param #(.WIDTH(4), .STEP(5), .SATURATE(1)) u_w4_sat (
    .CLK(clk), .RESET(rst), .ENABLE(en), .CASC_IN(casc), .MODO(modo),
    .CARGA(carga[3:0]), .Q(q3), .RCO(rco_v[3]), .OVF(ovf_v[3]));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_q(input int i);
    case (i)
      0: return {32'd0, q0};
      1: return {32'd0, q1};
      2: return {60'd0, q2};
      default: return {60'd0, q3};
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_q[i] = 0; m_rco[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endfunction

  // Next state of every variant from the counting rules, using the inputs present at the edge.
  function automatic void model_step();
    logic [63:0] mx;
    logic        evt;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      mx  = (64'd1 << vw[i]) - 1;
      evt = 1'b0;
      m_rco[i] = 1'b0;
      if (!en) begin
      end else if (modo == 2'd3) begin
        m_q[i]   = {32'd0, carga} & mx;
        m_ovf[i] = 1'b0;
      end else if (casc) begin
        case (modo)
          2'd0: begin
            evt    = (m_q[i] == mx);
            m_q[i] = evt ? (vsat[i] != 0 ? mx : 0) : m_q[i] + 1;
          end
          2'd1: begin
            evt    = (m_q[i] == 0);
            m_q[i] = evt ? (vsat[i] != 0 ? 0 : mx) : m_q[i] - 1;
          end
          default: begin
            evt    = (m_q[i] < 64'(vs[i]));
            m_q[i] = (evt && vsat[i] != 0) ? 0 : ((m_q[i] - 64'(vs[i])) & mx);
          end
        endcase
        if (evt) begin
          m_rco[i] = 1'b1;
          m_ovf[i] = 1'b1;
        end
      end
    end
  endfunction

  task automatic check_all(input string ph);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_q%0d", ph, i),   dut_q(i),     m_q[i]);
      check($sformatf("%s_rco%0d", ph, i), 64'(rco_v[i]), 64'(m_rco[i]));
      check($sformatf("%s_ovf%0d", ph, i), 64'(ovf_v[i]), 64'(m_ovf[i]));
    end
  endtask

  // One clock: model advances on the sampled inputs, outputs compared 1 time unit after the edge.
  task automatic cycle(input string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic drive(input logic e, input logic c, input logic [1:0] m, input logic [31:0] d);
    en = e; casc = c; modo = m; carga = d;
  endtask

  // Asynchronous reset pulse placed between edges; outputs must clear before the next edge.
  task automatic reset_pulse(input string ph);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(ph);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b1, 2'd0, 32'd0);
    model_reset();
    #1;
    check_all("reset_async");
    cycle("reset_hold");
    rst = 1'b0;

    // Count up five times from reset.
    drive(1'b1, 1'b1, 2'd0, 32'd0);
    for (int k = 0; k < 5; k++) cycle("up5");
    check("up5_const_q", {32'd0, q0}, 64'd5);

    // Load all-ones, then wrap / saturate on the up step.
    drive(1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF);
    cycle("load_ones");
    drive(1'b1, 1'b1, 2'd0, 32'd0);
    cycle("up_wrap");
    check("up_wrap_const_q", {32'd0, q0}, 64'd0);
    check("up_wrap_const_rco", 64'(rco_v[0]), 64'd1);
    check("up_sat_const_q", {32'd0, q1}, 64'hFFFF_FFFF);
    cycle("up_after");
    check("ovf_sticky_const", 64'(ovf_v[0]), 64'd1);

    // Load zero, then down by one.
    drive(1'b1, 1'b1, 2'd3, 32'd0);
    cycle("load_zero");
    check("load_clears_ovf", 64'(ovf_v[0]), 64'd0);
    drive(1'b1, 1'b1, 2'd1, 32'd0);
    cycle("dn_wrap");
    check("dn_wrap_const_q", {32'd0, q0}, 64'hFFFF_FFFF);
    cycle("dn_sat2");
    check("dn_sat_rco_repeat", 64'(rco_v[1]), 64'd1);

    // Load 4, then down by STEP twice.
    drive(1'b1, 1'b1, 2'd3, 32'd4);
    cycle("load_four");
    drive(1'b1, 1'b1, 2'd2, 32'd0);
    cycle("step1");
    check("step1_const_q", {32'd0, q0}, 64'd1);
    cycle("step2");
    check("step2_const_q", {32'd0, q0}, 64'hFFFF_FFFE);
    check("step2_sat_const_q", {32'd0, q1}, 64'd0);

    // Cascade and enable gating.
    drive(1'b1, 1'b0, 2'd0, 32'd0);
    cycle("casc_hold");
    drive(1'b1, 1'b0, 2'd3, 32'h1234);
    cycle("casc_load");
    check("casc_load_const_q", {32'd0, q0}, 64'h1234);
    drive(1'b0, 1'b1, 2'd3, 32'hABCD);
    cycle("en_noload");
    check("en_noload_const_q", {32'd0, q0}, 64'h1234);

    // Reset mid-count at 0x55, then resume.
    drive(1'b1, 1'b1, 2'd3, 32'h54);
    cycle("load_54");
    drive(1'b1, 1'b1, 2'd0, 32'd0);
    cycle("to_55");
    check("at_55_const_q", {32'd0, q0}, 64'h55);
    reset_pulse("mid_reset");
    check("mid_reset_const_q", {32'd0, q0}, 64'd0);
    cycle("resume");
    check("resume_const_q", {32'd0, q0}, 64'd1);

    // Random stimulus with loads biased toward the counting boundaries.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] d;
      case ($urandom_range(0, 4))
        0: d = 32'd0;
        1: d = 32'hFFFF_FFFF;
        2: d = 32'($urandom_range(0, 7));
        3: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: d = $urandom;
      endcase
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), d);
      cycle("rand");
      if ($urandom_range(0, 49) == 0) reset_pulse("rand_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
